// File: rtl/sync_ram_rdw.sv
// Single-port synchronous RAM with registered read, selectable
// read-during-write behaviour, optional output register, and a
// post-reset zero-fill sequencer.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_CLEAR | zero-filling mem[clr_cnt], accesses ignored, busy high
// S_IDLE  | normal operation, reads and writes accepted
module sync_ram_rdw #(
  parameter int    DATA_W         = 8,
  parameter int    ADDR_W         = 2,
  parameter int    RDW_MODE       = 0,
  parameter int    OUT_REG        = 0,
  parameter string INIT_FILE      = "",
  parameter bit    CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] d_o,
  output logic              d_o_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Select write source: the clear sequencer owns the port while clearing.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = a;
    mem_wd = d_i;
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_cnt;
        mem_wd = '0;
      end else if (we) begin
        mem_we = 1'b1;
      end
    end
  end

  // Memory array write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Clear sequencer and stage-1 read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt  <= '0;
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          s1_valid <= 1'b0;
          clr_cnt  <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= S_IDLE;
        end
        default: begin
          // No-change mode suppresses the capture when a write collides.
          if (re && !(we && (RDW_MODE == 2))) begin
            // Non-blocking write makes mem[a] the pre-write (old) value here.
            s1_data  <= (we && (RDW_MODE == 1)) ? d_i : mem[a];
            s1_valid <= 1'b1;
          end else begin
            s1_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = (state == S_CLEAR);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Second output stage adds one clock of read latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          d_o       <= '0;
          d_o_valid <= 1'b0;
        end else begin
          d_o       <= s1_data;
          d_o_valid <= s1_valid;
        end
      end
    end else begin : g_out_direct
      assign d_o       = s1_data;
      assign d_o_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sync_ram_rdw.sv
// Bench for sync_ram_rdw: five instances share one stimulus stream
// (read-first, write-first, no-change, pipelined, no-clear). A reference
// memory per instance predicts read data, which is queued with its due
// cycle and matched against d_o / d_o_valid after every edge.
module tb_sync_ram_rdw;

  localparam int N = 5;
  localparam int MODE [N] = '{0, 1, 2, 0, 0};
  localparam int OREG [N] = '{0, 0, 0, 1, 0};
  localparam int CLR  [N] = '{1, 1, 1, 1, 0};

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk_tb = 1'b0;
  logic       rst, we, re;
  logic [1:0] a;
  logic [7:0] d_i;
  logic [7:0] d_o       [N];
  logic       d_o_valid [N];
  logic       busy      [N];

  logic [7:0] mem_m     [N][4];
  int         clr_left  [N];
  logic [7:0] last_do   [N];
  exp_t       sb        [N][$];

  int cycle    = 0;
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_tb = ~clk_tb;

  generate
    for (genvar k = 0; k < N; k++) begin : g_dut
      sync_ram_rdw #(
        .DATA_W        (8),
        .ADDR_W        (2),
        .RDW_MODE      (MODE[k]),
        .OUT_REG       (OREG[k]),
        .INIT_FILE     (""),
        .CLEAR_ON_RESET(CLR[k] != 0)
      ) u_dut (
        .clk      (clk_tb),
        .rst      (rst),
        .we       (we),
        .re       (re),
        .a        (a),
        .d_i      (d_i),
        .d_o      (d_o[k]),
        .d_o_valid(d_o_valid[k]),
        .busy     (busy[k])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Predict the effect of the coming edge on every instance.
  task automatic model_edge(input logic r, input logic w, input logic rd,
                            input logic [1:0] aa, input logic [7:0] dd);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (r) begin
        clr_left[k] = (CLR[k] != 0) ? 4 : 0;
        sb[k].delete();
        last_do[k] = 8'h00;
      end else if (clr_left[k] > 0) begin
        mem_m[k][4 - clr_left[k]] = 8'h00;
        clr_left[k]--;
      end else begin
        if (rd && !(w && MODE[k] == 2)) begin
          e.data = (w && MODE[k] == 1) ? dd : mem_m[k][aa];
          e.due  = cycle + 1 + OREG[k];
          sb[k].push_back(e);
        end
        if (w) mem_m[k][aa] = dd;
      end
    end
  endtask

  task automatic sample();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      check($sformatf("u%0d busy", k), 32'(busy[k]), 32'(clr_left[k] > 0));
      if (sb[k].size() > 0 && sb[k][0].due == cycle) begin
        e = sb[k].pop_front();
        check($sformatf("u%0d valid", k), 32'(d_o_valid[k]), 32'(1));
        check($sformatf("u%0d d_o", k), 32'(d_o[k]), 32'(e.data));
        last_do[k] = e.data;
      end else begin
        check($sformatf("u%0d valid_idle", k), 32'(d_o_valid[k]), 32'(0));
        check($sformatf("u%0d d_o_hold", k), 32'(d_o[k]), 32'(last_do[k]));
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [1:0] aa, input logic [7:0] dd);
    rst = r; we = w; re = rd; a = aa; d_i = dd;
    model_edge(r, w, rd, aa, dd);
    @(posedge clk_tb);
    cycle++;
    #1;
    sample();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      clr_left[k] = 0;
      last_do[k]  = 8'h00;
      for (int j = 0; j < 4; j++) mem_m[k][j] = 8'hxx;
    end
    rst = 1'b1; we = 1'b0; re = 1'b0; a = 2'd0; d_i = 8'h00;
    #1;

    // Reset for two clocks, release, then restart the clear on its third edge.
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'hE0);
    step(0, 1, 1, 1, 8'hE1);
    step(1, 0, 0, 0, 8'h00);
    // Writes and reads during the clear must be lost on clearing instances.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'(i), 8'hEE);

    // Cleared contents read back as zero.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'(i), 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Read-during-write on address 1, then a plain read of it.
    step(0, 1, 0, 1, 8'h11);
    step(0, 1, 1, 1, 8'h22);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Fill and read back to back.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'(i), 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Write one address, read a different one next cycle, then the written one.
    step(0, 1, 0, 2, 8'h55);
    step(0, 0, 1, 3, 8'h00);
    step(0, 1, 0, 3, 8'h66);
    step(0, 0, 1, 2, 8'h00);
    step(0, 0, 1, 3, 8'h00);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

    // Reset with reads in flight, then let the clear run.
    step(0, 0, 1, 0, 8'h00);
    step(1, 0, 1, 1, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'(i), 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    for (int k = 0; k < N; k++)
      check($sformatf("u%0d sb_empty", k), 32'(sb[k].size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
